dmem_unit: RTL and testbench
============================

DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 Parameter ADDR_W, default 7: word-address bits; depth = 2**ADDR_W words.
REQ-002 Parameter LATENCY, default 1, range 0..15: stall cycles per CPU access.
REQ-003 Parameter INIT_ZERO, default 1: when 1, the array powers up all-zero in simulation.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 MemReadM  in  1  load request.
REQ-007 MemWriteM  in  1  store request.
REQ-008 MemSizeM  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-009 MemSignedM  in  1  load extension: 1 sign-extend, 0 zero-extend.
REQ-010 ALUOutM  in  32  byte address.
REQ-011 WriteDataM  in  32  store data, right-aligned.
REQ-012 if_end  in  1  debug mode: program finished, array read through address.
REQ-013 address  in  ADDR_W  debug word address.
REQ-014 ReadDataM  out  32  load data, or the debug word while if_end=1.
REQ-015 StallM  out  1  pipeline hold; the pipeline keeps all M inputs stable while it is high.
REQ-016 MisalignM  out  1  misaligned-access flag (see Configuration).

Function
REQ-017 Word index = ALUOutM[ADDR_W+1:2]; higher address bits are ignored (wrap modulo depth).
REQ-018 Little-endian lanes: a byte uses lane ALUOutM[1:0]; a half uses lanes {ALUOutM[1],0}+1..0.
REQ-019 Stores replicate the data into every lane and write only the enabled lanes; other bytes are preserved.
REQ-020 Loads extract the addressed lane(s) and extend them to 32 bits per MemSignedM; a word load is passed through unchanged.
REQ-021 FSM states: IDLE, WAIT, DONE; a request is MemReadM|MemWriteM while if_end=0.
REQ-022 LATENCY=0: the FSM stays in IDLE; StallM=0; the store commits on the edge of the request cycle; load data is combinational in the same cycle.
REQ-023 LATENCY>=1, IDLE with a request: StallM=1 combinationally; the 4-bit counter loads LATENCY-1; go to WAIT.
REQ-024 WAIT: StallM=1; decrement the counter; when it reads 0, go to DONE.
REQ-025 DONE: StallM=0; ReadDataM is valid; the store commits on the closing edge; go to IDLE; exactly LATENCY stall cycles occur per access.
REQ-026 A request present in the cycle after DONE starts a new access; there is no bubble requirement.
REQ-027 MemReadM and MemWriteM both high: treat as a store; ReadDataM returns the pre-store contents.
REQ-028 if_end=1: force IDLE; StallM=0; no write commits; ReadDataM = array[address] combinationally.
REQ-029 if_end rising during WAIT: abort the access; the store is discarded.
REQ-030 ReadDataM outside DONE (LATENCY>=1) and outside debug mode is don't-care.

Reset
REQ-031 rst=1 at a clock edge: state IDLE, counter 0, no write commits.
REQ-032 While rst=1: StallM=0, MisalignM=0, ReadDataM=0.
REQ-033 Reset mid-access drops the access; array contents are retained across reset.

Configuration
REQ-034 Macro DMEM_MISALIGN_TRAP_EN defined: MisalignM=1 for a half with ALUOutM[0]=1 or a word with ALUOutM[1:0]!=0, valid in the cycle StallM falls or in the request cycle when LATENCY=0; a misaligned store does not write; a misaligned load returns 0.
REQ-035 Macro undefined: MisalignM is tied to 0; the low address bits are masked to the natural alignment of the size.

Structure
REQ-036 Package dmem_pkg holds: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, and LATENCY counter width constant.
REQ-037 Sub-module dmem_array: 2**ADDR_W x 32 storage with a 4-bit byte-enable synchronous write, one combinational read port for the CPU and one for debug.

Verification
REQ-038 LATENCY=0: store word 0xDEADBEEF at 0x10, then load word 0x10 -> ReadDataM=0xDEADBEEF the next cycle; StallM never 1.
REQ-039 LATENCY=3: load request -> StallM high 3 cycles, low in DONE with the data; the next request is accepted the cycle after DONE.
REQ-040 Byte store 0x000000A5 at 0x13 over word 0x11223344 -> word 0xA5223344; signed byte load 0x13 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
REQ-041 Half store 0x8001 at 0x22, signed half load 0x22 -> 0xFFFF8001; with DMEM_MISALIGN_TRAP_EN, word store at 0x21 -> MisalignM=1, memory unchanged.
REQ-042 rst asserted during WAIT of a store at 0x30 -> StallM=0 the next cycle, word 0x30 unchanged; if_end=1, address=0x04 -> ReadDataM=array[4] with no stall.
REQ-043 ALUOutM=0x200+0x08 with ADDR_W=7 -> access aliases word index 2.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory unit.
//   SZ_BYTE/SZ_HALF/SZ_WORD : MemSizeM encodings (2'b11 is handled as a word)
//   CNT_W                   : width of the access-latency down-counter
//   state_t                 : access FSM states
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array -- 2**ADDR_W x 32 storage, byte-enable synchronous write,
// two combinational read ports.
//   clk       : write clock
//   we, be    : write enable and per-byte lane enables
//   cpu_addr  : word address shared by the write port and the CPU read port
//   wdata     : write data (already lane-replicated)
//   cpu_rdata : CPU read data
//   dbg_addr  : debug word address
//   dbg_rdata : debug read data
// INIT_ZERO=1 gives the array an all-zero initial value in simulation.
module dmem_array #(
   parameter int unsigned ADDR_W    = 7,
   parameter bit          INIT_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       cpu_rdata,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [31:0]       dbg_rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   generate
      if (INIT_ZERO) begin : g_init
         logic [31:0] mem_q [DEPTH] = '{default: '0};

         always_ff @(posedge clk) begin
            if (we) begin
               for (int unsigned i = 0; i < 4; i++) begin
                  if (be[i]) mem_q[cpu_addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end

         assign cpu_rdata = mem_q[cpu_addr];
         assign dbg_rdata = mem_q[dbg_addr];
      end else begin : g_noinit
         logic [31:0] mem_q [DEPTH];

         always_ff @(posedge clk) begin
            if (we) begin
               for (int unsigned i = 0; i < 4; i++) begin
                  if (be[i]) mem_q[cpu_addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end

         assign cpu_rdata = mem_q[cpu_addr];
         assign dbg_rdata = mem_q[dbg_addr];
      end
   endgenerate

endmodule

// File: rtl/dmem_unit.sv
// dmem_unit -- pipeline data memory with configurable access latency.
//   clk, rst       : clock, synchronous active-high reset
//   MemReadM/WriteM: load / store request (both high = store, returns old data)
//   MemSizeM       : 00 byte, 01 half, 10/11 word
//   MemSignedM     : sign-extend sub-word loads
//   ALUOutM        : byte address (word index wraps modulo depth)
//   WriteDataM     : right-aligned store data
//   if_end, address: debug mode, array word read at 'address'
//   ReadDataM      : load data / debug word
//   StallM         : hold the pipeline for LATENCY cycles per access
//   MisalignM      : misaligned-access flag
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (flag and suppress misaligned
// accesses; when undefined the low address bits are masked to size alignment).
module dmem_unit
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W    = 7,
   parameter int unsigned LATENCY   = 1,
   parameter bit          INIT_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   input  logic [1:0]        MemSizeM,
   input  logic              MemSignedM,
   input  logic [31:0]       ALUOutM,
   input  logic [31:0]       WriteDataM,
   input  logic              if_end,
   input  logic [ADDR_W-1:0] address,
   output logic [31:0]       ReadDataM,
   output logic              StallM,
   output logic              MisalignM
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic              req;
   logic              in_done;
   logic              wr_en;
   logic              misalign;
   logic              is_byte, is_half, is_word;
   logic [1:0]        lane_lo;
   logic [ADDR_W-1:0] index;
   logic [3:0]        wr_be;
   logic [31:0]       wr_data;
   logic [31:0]       cpu_rdata, dbg_rdata, ld_data;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic              unused_addr_hi;

   assign req   = (MemReadM | MemWriteM) & ~if_end;
   assign index = ALUOutM[ADDR_W+1:2];
   assign unused_addr_hi = ^ALUOutM[31:ADDR_W+2];

   assign is_byte = (MemSizeM == SZ_BYTE);
   assign is_half = (MemSizeM == SZ_HALF);
   assign is_word = (MemSizeM == SZ_WORD) | (MemSizeM == 2'b11);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign lane_lo   = ALUOutM[1:0];
   assign misalign  = (is_half & ALUOutM[0]) | (is_word & (ALUOutM[1:0] != 2'b00));
   assign MisalignM = ~rst & in_done & misalign;
`else
   assign lane_lo   = is_word ? 2'b00 : (is_half ? {ALUOutM[1], 1'b0} : ALUOutM[1:0]);
   assign misalign  = 1'b0;
   assign MisalignM = 1'b0;
`endif

   // Data is valid and a store commits in the request cycle (LATENCY=0) or in DONE.
   assign in_done = req & ((LATENCY == 0) | (state_q == DONE));
   assign wr_en   = ~rst & in_done & MemWriteM & ~misalign;

   // WAIT holds the stall on state alone so a dropped access cannot leave it asserted.
   assign StallM = ~rst & (LATENCY != 0) &
                   ((req & (state_q == IDLE)) | (~if_end & (state_q == WAIT)));

   always_comb begin
      wr_data = WriteDataM;
      wr_be   = 4'b1111;
      ld_byte = cpu_rdata[{lane_lo, 3'b000} +: 8];
      ld_half = cpu_rdata[{lane_lo[1], 4'b0000} +: 16];
      ld_data = cpu_rdata;
      if (is_byte) begin
         wr_data = {4{WriteDataM[7:0]}};
         wr_be   = 4'b0001 << lane_lo;
         ld_data = {{24{MemSignedM & ld_byte[7]}}, ld_byte};
      end else if (is_half) begin
         wr_data = {2{WriteDataM[15:0]}};
         wr_be   = lane_lo[1] ? 4'b1100 : 4'b0011;
         ld_data = {{16{MemSignedM & ld_half[15]}}, ld_half};
      end
   end

   always_comb begin
      if (rst)           ReadDataM = '0;
      else if (if_end)   ReadDataM = dbg_rdata;
      else if (misalign) ReadDataM = '0;
      else               ReadDataM = ld_data;
   end

   // The request cycle itself is the first stall cycle, so WAIT covers
   // LATENCY-1 cycles and LATENCY=1 goes straight to DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req && (LATENCY != 0)) begin
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = (LATENCY == 1) ? DONE : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_d == '0) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (if_end) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   dmem_array #(
      .ADDR_W   (ADDR_W),
      .INIT_ZERO(INIT_ZERO)
   ) u_array (
      .clk      (clk),
      .we       (wr_en),
      .be       (wr_be),
      .cpu_addr (index),
      .wdata    (wr_data),
      .cpu_rdata(cpu_rdata),
      .dbg_addr (address),
      .dbg_rdata(dbg_rdata)
   );

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit -- directed bench for dmem_unit with a LATENCY=0 and a
// LATENCY=3 instance sharing address/data/debug inputs; each has its own
// request strobes and its own memory model.
`timescale 1ns/1ps
module tb_dmem_unit;

   localparam int unsigned AW    = 7;
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned LAT0  = 0;
   localparam int unsigned LAT3  = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          rd0, wr0, rd3, wr3;
   logic [1:0]    size;
   logic          sgn;
   logic [31:0]   addr, wdata;
   logic          if_end;
   logic [AW-1:0] dbg_addr;
   logic [31:0]   rdata0, rdata3;
   logic          st0, st3, mis0, mis3;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_m [2][DEPTH];
   int unsigned age   [2];

   always #5 clk = ~clk;

   dmem_unit #(.ADDR_W(AW), .LATENCY(LAT0), .INIT_ZERO(1'b1)) u_l0 (
      .clk(clk), .rst(rst), .MemReadM(rd0), .MemWriteM(wr0), .MemSizeM(size),
      .MemSignedM(sgn), .ALUOutM(addr), .WriteDataM(wdata), .if_end(if_end),
      .address(dbg_addr), .ReadDataM(rdata0), .StallM(st0), .MisalignM(mis0));

   dmem_unit #(.ADDR_W(AW), .LATENCY(LAT3), .INIT_ZERO(1'b1)) u_l3 (
      .clk(clk), .rst(rst), .MemReadM(rd3), .MemWriteM(wr3), .MemSizeM(size),
      .MemSignedM(sgn), .ALUOutM(addr), .WriteDataM(wdata), .if_end(if_end),
      .address(dbg_addr), .ReadDataM(rdata3), .StallM(st3), .MisalignM(mis3));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h want=%08h", name, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int unsigned lat_of(input int k);
      return (k == 0) ? LAT0 : LAT3;
   endfunction

   function automatic bit rd_of(input int k);
      return (k == 0) ? rd0 : rd3;
   endfunction

   function automatic bit wr_of(input int k);
      return (k == 0) ? wr0 : wr3;
   endfunction

   function automatic bit req_of(input int k);
      return (rd_of(k) || wr_of(k)) && !if_end;
   endfunction

   function automatic bit mis_f(input logic [1:0] sz, input logic [31:0] a);
      bit m;
      m = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (sz == 2'b01) m = a[0];
      else if (sz[1])  m = (a[1:0] != 2'b00);
`else
      m = (sz == 2'b00) && (a == 32'h0) && 1'b0;
`endif
      return m;
   endfunction

   function automatic int unsigned idx_f(input logic [31:0] a);
      return (a >> 2) % DEPTH;
   endfunction

   function automatic logic [31:0] load_f(input logic [31:0] w, input logic [1:0] sz,
                                          input bit sg, input logic [31:0] a);
      int unsigned sh;
      logic [31:0] v;
      if (mis_f(sz, a)) return 32'h0;
      if (sz == 2'b00) begin
         sh = (a % 4) * 8;
         v  = (w >> sh) & 32'hFF;
         if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
         sh = ((a % 4) / 2) * 16;
         v  = (w >> sh) & 32'hFFFF;
         if (sg && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] store_f(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [31:0] d, input logic [31:0] a);
      int unsigned sh;
      logic [31:0] m;
      if (sz == 2'b00) begin
         sh = (a % 4) * 8;
         m  = 32'hFF << sh;
         return (w & ~m) | ((d & 32'hFF) << sh);
      end else if (sz == 2'b01) begin
         sh = ((a % 4) / 2) * 16;
         m  = 32'hFFFF << sh;
         return (w & ~m) | ((d & 32'hFFFF) << sh);
      end
      return d;
   endfunction

   // age = cycles the current request has been presented; it completes when age == latency
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst || !req_of(k)) begin
            age[k] = 0;
         end else if (age[k] == lat_of(k)) begin
            if (wr_of(k) && !mis_f(size, addr))
               mem_m[k][idx_f(addr)] = store_f(mem_m[k][idx_f(addr)], size, wdata, addr);
            age[k] = 0;
         end else begin
            age[k] = age[k] + 1;
         end
      end
   end

   // compare process
   always @(negedge clk) begin
      logic [31:0] got_rd;
      logic        got_st, got_mis, done;
      for (int k = 0; k < 2; k++) begin
         got_rd  = (k == 0) ? rdata0 : rdata3;
         got_st  = (k == 0) ? st0 : st3;
         got_mis = (k == 0) ? mis0 : mis3;
         done    = !rst && req_of(k) && (age[k] == lat_of(k));
         check($sformatf("stall%0d", k), 32'(got_st),
               32'(!rst && req_of(k) && (age[k] < lat_of(k))));
         check($sformatf("misalign%0d", k), 32'(got_mis), 32'(done && mis_f(size, addr)));
         if (rst)
            check($sformatf("rst_rdata%0d", k), got_rd, 32'h0);
         else if (if_end)
            check($sformatf("dbg_rdata%0d", k), got_rd, mem_m[k][dbg_addr]);
         else if (done && rd_of(k))
            check($sformatf("load%0d", k), got_rd,
                  load_f(mem_m[k][idx_f(addr)], size, sgn, addr));
      end
   end

   // ---------------- stimulus ----------------
   task automatic acc(input int k, input bit rd, input bit wr, input logic [1:0] sz,
                      input bit sg, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rdata, output int stalls);
      if (k == 0) begin rd0 = rd; wr0 = wr; end
      else        begin rd3 = rd; wr3 = wr; end
      size = sz; sgn = sg; addr = a; wdata = wd;
      stalls = 0;
      @(negedge clk);
      while (((k == 0) ? st0 : st3) && stalls < 40) begin
         stalls++;
         @(negedge clk);
      end
      rdata = (k == 0) ? rdata0 : rdata3;
      @(posedge clk); #1;
      if (k == 0) begin rd0 = 1'b0; wr0 = 1'b0; end
      else        begin rd3 = 1'b0; wr3 = 1'b0; end
   endtask

   initial begin
      logic [31:0] r;
      int          s;
      rst = 1'b1; rd0 = 1'b0; wr0 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
      size = 2'b10; sgn = 1'b0; addr = '0; wdata = '0;
      if_end = 1'b0; dbg_addr = '0;
      age[0] = 0; age[1] = 0;
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < int'(DEPTH); i++) mem_m[k][i] = 32'h0;

      @(negedge clk);
      check("reset_rdata", rdata3, 32'h0);
      check("reset_stall", 32'(st3), 32'h0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;

      // LATENCY=0: no stall, same-cycle load
      acc(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, r, s);
      check("l0_store_stalls", 32'(s), 32'd0);
      acc(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, r, s);
      check("l0_load_word", r, 32'hDEADBEEF);
      check("l0_load_stalls", 32'(s), 32'd0);

      // LATENCY=3: back-to-back accesses, 3 stalls each
      acc(1, 0, 1, 2'b10, 0, 32'h10, 32'h11223344, r, s);
      check("l3_store_stalls", 32'(s), 32'd3);
      acc(1, 0, 1, 2'b00, 0, 32'h13, 32'h000000A5, r, s);
      acc(1, 1, 0, 2'b00, 1, 32'h13, 32'h0, r, s);
      check("byte_signed", r, 32'hFFFFFFA5);
      check("l3_load_stalls", 32'(s), 32'd3);
      acc(1, 1, 0, 2'b00, 0, 32'h13, 32'h0, r, s);
      check("byte_unsigned", r, 32'h000000A5);
      acc(1, 1, 0, 2'b10, 0, 32'h10, 32'h0, r, s);
      check("byte_merge", r, 32'hA5223344);

      acc(1, 0, 1, 2'b01, 0, 32'h22, 32'h00008001, r, s);
      acc(1, 1, 0, 2'b01, 1, 32'h22, 32'h0, r, s);
      check("half_signed", r, 32'hFFFF8001);
      acc(1, 1, 0, 2'b00, 1, 32'h23, 32'h0, r, s);
      check("half_hi_byte", r, 32'hFFFFFF80);

      // read+write together: store, returning old contents
      acc(1, 1, 1, 2'b10, 0, 32'h10, 32'h00000055, r, s);
      check("rw_old_data", r, 32'hA5223344);
      acc(1, 1, 0, 2'b10, 0, 32'h10, 32'h0, r, s);
      check("rw_new_data", r, 32'h00000055);

      // misaligned word store at 0x21
      acc(1, 0, 1, 2'b10, 0, 32'h21, 32'hCAFEF00D, r, s);
      acc(1, 1, 0, 2'b10, 0, 32'h20, 32'h0, r, s);
`ifdef DMEM_MISALIGN_TRAP_EN
      check("misalign_store", r, 32'h80010000);
`else
      check("masked_store", r, 32'hCAFEF00D);
`endif

      // address wrap: 0x208 aliases word index 2
      acc(1, 0, 1, 2'b10, 0, 32'h208, 32'h0BADCAFE, r, s);
      acc(1, 1, 0, 2'b10, 0, 32'h08, 32'h0, r, s);
      check("alias_wrap", r, 32'h0BADCAFE);

      // reset during WAIT of a store to 0x30
      wr3 = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'h77777777;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_in_wait_stall", 32'(st3), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; wr3 = 1'b0;
      @(negedge clk);
      check("post_rst_stall", 32'(st3), 32'h0);

      // debug reads
      @(posedge clk); #1;
      if_end = 1'b1; dbg_addr = 7'd12;
      @(negedge clk);
      check("dbg_0x30_kept", rdata3, 32'h0);
      @(posedge clk); #1;
      dbg_addr = 7'd4;
      @(negedge clk);
      check("dbg4_l3", rdata3, 32'h00000055);
      check("dbg4_l0", rdata0, 32'hDEADBEEF);
      check("dbg_no_stall", 32'(st3), 32'h0);

      // if_end rising during WAIT aborts a store to 0x34
      @(posedge clk); #1;
      if_end = 1'b0; wr3 = 1'b1; addr = 32'h34; wdata = 32'h99999999;
      @(posedge clk); #1;
      if_end = 1'b1;
      @(posedge clk); #1;
      wr3 = 1'b0; dbg_addr = 7'd13;
      @(negedge clk);
      check("abort_no_write", rdata3, 32'h0);
      @(posedge clk); #1;
      if_end = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
